// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the UART receive path.
//   rx_state_t  : receiver FSM states
//   DEF_*       : default build parameters
//   cnt_width() : counter width able to index n values (minimum 1)
//   TICK_CNT_W / BIT_CNT_W : counter widths for the default build
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned TICK_CNT_W = cnt_width(DEF_OVERSAMPLE);
    localparam int unsigned BIT_CNT_W  = cnt_width(DEF_DATA_BITS);

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with wrap-around pointers and an occupancy count.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/data_i: write request and data; accepted when not full or when
//                  a pop happens in the same cycle
//   pop_i        : remove head; ignored while empty
//   data_o       : head entry, forced to 0 while empty
//   full_o       : all entries occupied
//   empty_o      : no entries
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_BITS,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

    // A pop frees the slot a same-cycle push needs when full.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_rx_mac.sv
// UART receiver: 2-flop rx synchronizer, oversampled 8N1 framing FSM,
// receive FIFO and good-byte / framing-error counters.
//   system_clock   : single clock domain
//   rst            : asynchronous active-high reset
//   sample_enable  : one-cycle strobe at OVERSAMPLE x baud
//   rx             : async serial input, idles high
//   rd_en          : pop FIFO head (ignored while rd_valid=0)
//   clear_counters : sync clear of byte_count, err_count, overflow
//   rd_data        : FIFO head, valid while rd_valid=1
//   rd_valid       : FIFO not empty
//   frame_error    : one-cycle pulse after a stop bit sampled low
//   overflow       : sticky, a received byte was dropped on a full FIFO
//   busy           : FSM not idle
//   byte_count     : good bytes received, wraps
//   err_count      : framing errors, saturates
module uart_rx_mac
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 system_clock,
    input  logic                 rst,
    input  logic                 sample_enable,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic                 clear_counters,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 frame_error,
    output logic                 overflow,
    output logic                 busy,
    output logic [15:0]          byte_count,
    output logic [7:0]           err_count
);

    // Counters are never narrower than in the default build.
    localparam int unsigned TICK_W = (cnt_width(OVERSAMPLE) > TICK_CNT_W) ?
                                     cnt_width(OVERSAMPLE) : TICK_CNT_W;
    localparam int unsigned BIT_W  = (cnt_width(DATA_BITS) > BIT_CNT_W) ?
                                     cnt_width(DATA_BITS) : BIT_CNT_W;

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE/2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    rx_state_t            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [15:0]          byte_count_q, byte_count_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_error_q;
    logic                 push_w;
    logic                 ferr_w;
    logic                 drop_w;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Synchronizer flops reset to the idle line level.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Tick/bit counters and shift register.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state logic; everything advances only on sample_enable.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (sample_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        // LSB arrives first and ends up at bit 0 after the last shift.
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = rx_s_q ? IDLE : WAIT_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: push or framing error on the mid-stop sample.
    always_comb begin
        push_w = 1'b0;
        ferr_w = 1'b0;
        busy   = (state_q != IDLE);
        if (sample_enable && (state_q == STOP) && (tick_q == BIT_LAST)) begin
            push_w = rx_s_q;
            ferr_w = !rx_s_q;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (system_clock),
        .rst_i   (rst),
        .push_i  (push_w),
        .data_i  (shreg_q),
        .pop_i   (rd_en),
        .data_o  (rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A pop on a full FIFO makes room, so only an unpaired push is dropped.
    assign drop_w = push_w && fifo_full && !(rd_en && !fifo_empty);

    always_comb begin
        byte_count_d = byte_count_q;
        err_count_d  = err_count_q;
        overflow_d   = overflow_q;
        if (clear_counters) begin
            byte_count_d = '0;
            err_count_d  = '0;
            overflow_d   = 1'b0;
        end else begin
            if (push_w) byte_count_d = byte_count_q + 1'b1;
            if (ferr_w && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
            if (drop_w) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            byte_count_q  <= '0;
            err_count_q   <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            byte_count_q  <= byte_count_d;
            err_count_q   <= err_count_d;
            overflow_q    <= overflow_d;
            frame_error_q <= ferr_w;
        end
    end

    assign rd_valid    = !fifo_empty;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;
    assign byte_count  = byte_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_rx_mac.sv
// Self-checking bench for uart_rx_mac: serial frames are generated at
// OVERSAMPLE ticks per bit and results compared against a frame-level
// reference model (byte queue plus counters).
module tb_uart_rx_mac;

    localparam int unsigned OS       = 16;
    localparam int          ACT_NONE = 0;
    localparam int          ACT_POP  = 1;
    localparam int          ACT_CLR  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        se;
    logic        rx;
    logic        rd_en;
    logic        clr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        frame_error;
    logic        overflow;
    logic        busy;
    logic [15:0] byte_count;
    logic [7:0]  err_count;

    int unsigned se_div  = 4;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          fe_seen  = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    int          m_bc  = 0;
    int          m_err = 0;
    int          m_ov  = 0;
    int          m_fe  = 0;

    uart_rx_mac #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .system_clock   (clk),
        .rst            (rst),
        .sample_enable  (se),
        .rx             (rx),
        .rd_en          (rd_en),
        .clear_counters (clr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .frame_error    (frame_error),
        .overflow       (overflow),
        .busy           (busy),
        .byte_count     (byte_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    // sample_enable: high for one clock every se_div clocks
    initial begin
        int unsigned cnt;
        cnt = 0;
        se  = 1'b0;
        forever begin
            @(negedge clk);
            cnt++;
            if (cnt >= se_div) begin
                cnt = 0;
                se  = 1'b1;
            end else begin
                se = 1'b0;
            end
        end
    end

    always @(negedge clk) if (frame_error === 1'b1) fe_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_ticks(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            while (se !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    // Frame-level model: one call per complete character on the line.
    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input int act);
        logic [7:0] junk;
        if (stop_ok) begin
            if (act == ACT_POP && m_q.size() > 0) junk = m_q.pop_front();
            m_bc = (m_bc + 1) % 65536;
            if (m_q.size() >= 4) m_ov = 1;
            else m_q.push_back(d);
        end else begin
            m_fe++;
            if (m_err < 255) m_err++;
        end
        if (act == ACT_CLR) begin
            m_bc  = 0;
            m_err = 0;
            m_ov  = 0;
        end
    endtask

    // Sends one 8N1 character. act fires rd_en or clear_counters for
    // exactly the clock of the mid-stop sample (only used with se_div=4).
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int unsigned low_extra, input int act);
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(OS);
        end
        rx = stop_ok;
        if (act != ACT_NONE) begin
            wait_ticks(OS/2);
            repeat (3) @(negedge clk);
            if (act == ACT_POP) rd_en = 1'b1;
            else                clr   = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            clr   = 1'b0;
            wait_ticks(OS/2 - 1);
        end else begin
            wait_ticks(OS);
        end
        if (!stop_ok) begin
            wait_ticks(low_extra);
            rx = 1'b1;
            wait_ticks(4);
        end else begin
            wait_ticks(2);
        end
        model_frame(d, stop_ok, act);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_valid"}, rd_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check_eq({tag, "_data"}, rd_data, m_q[0]);
        else                check_eq({tag, "_data0"}, rd_data, 0);
        check_eq({tag, "_bytes"}, byte_count, m_bc);
        check_eq({tag, "_errs"}, err_count, m_err);
        check_eq({tag, "_ovf"}, overflow, m_ov);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_fe_pulses"}, fe_seen, m_fe);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] junk;
        check_eq({tag, "_pv"}, rd_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check_eq({tag, "_pd"}, rd_data, m_q[0]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        if (m_q.size() > 0) junk = m_q.pop_front();
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        m_bc  = 0;
        m_err = 0;
        m_ov  = 0;
    endtask

    task automatic apply_reset(input string tag);
        rst   = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        m_q.delete();
        m_bc  = 0;
        m_err = 0;
        m_ov  = 0;
        check_eq({tag, "_valid"}, rd_valid, 0);
        check_eq({tag, "_data"}, rd_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_bytes"}, byte_count, 0);
        check_eq({tag, "_errs"}, err_count, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
        check_eq({tag, "_fe"}, frame_error, 0);
        rst = 1'b0;
        wait_ticks(3);
    endtask

    initial begin
        logic [7:0] d;
        bit         ok;

        rst   = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        clr   = 1'b0;
        apply_reset("reset");

        // 1: clean character
        send_frame(8'hA5, 1'b1, 0, ACT_NONE);
        check_state("t1");
        check_eq("t1_const_data", rd_data, 8'hA5);
        check_eq("t1_const_bytes", byte_count, 1);
        pop_one("t1_pop");

        // 2: start-bit glitch
        rx = 1'b0;
        wait_ticks(4);
        check_eq("t2_busy_hi", busy, 1);
        rx = 1'b1;
        wait_ticks(12);
        check_state("t2");

        // 3: bad stop bit held low as a break, then a good character
        pulse_clear();
        send_frame(8'h3C, 1'b0, 40, ACT_NONE);
        check_state("t3_err");
        check_eq("t3_const_errs", err_count, 1);
        send_frame(8'h11, 1'b1, 0, ACT_NONE);
        check_state("t3_ok");
        pop_one("t3_pop");

        // random characters, random stop quality and pops
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok, $urandom_range(0, 8), ACT_NONE);
            check_state("rnd");
            if ($urandom_range(0, 1) == 1) pop_one("rnd_pop");
        end

        // 4: overflow and pop on the push cycle of a full FIFO
        while (m_q.size() > 0) pop_one("t4_drain");
        pulse_clear();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, ACT_NONE);
        check_state("t4_full");
        check_eq("t4_const_ovf", overflow, 1);
        check_eq("t4_const_bytes", byte_count, 5);
        pulse_clear();
        check_eq("t4_clr_ovf", overflow, 0);
        send_frame(8'h06, 1'b1, 0, ACT_POP);
        check_state("t4_poppush");
        for (int i = 0; i < 4; i++) pop_one("t4_read");
        check_eq("t4_empty", rd_valid, 0);

        // 5: reset in the middle of data bit 4
        send_frame(8'h5A, 1'b1, 0, ACT_NONE);
        check_state("t5_pre");
        rx = 1'b0;
        wait_ticks(OS);
        d = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_ticks(OS);
        end
        rx = d[4];
        wait_ticks(OS/2);
        check_eq("t5_busy_mid", busy, 1);
        apply_reset("t5_rst");
        send_frame(8'h7E, 1'b1, 0, ACT_NONE);
        check_state("t5_post");
        check_eq("t5_const_data", rd_data, 8'h7E);
        pop_one("t5_pop");

        // 6: error counter saturation (fast strobe keeps the run short)
        se_div = 1;
        wait_ticks(4);
        for (int i = 0; i < 256; i++) send_frame(8'($urandom), 1'b0, 0, ACT_NONE);
        check_state("t6_sat");
        check_eq("t6_const_errs", err_count, 255);
        se_div = 4;
        wait_ticks(4);
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 0, ACT_NONE);
        check_eq("t6_full_ovf", overflow, 0);
        send_frame(8'h99, 1'b1, 0, ACT_CLR);
        check_state("t6_clr");
        check_eq("t6_const_bytes", byte_count, 0);
        check_eq("t6_const_errs0", err_count, 0);
        check_eq("t6_const_ovf0", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
